chan_sel_array: RTL and testbench
=================================

// Module: chan_sel_array
// PURPOSE
//  - Parametrised multi-channel holding array: NUM_CH single-word slots, each instantiated as
//    chan_loop[i].slot_inst of sub-module chan_slot in a generate loop.
//  - Writers deposit words into a selected slot. A drain FSM selects slots by runtime index
//    (round-robin mode) or by a parameter-derived index (fixed mode) and presents them on a
//    valid/ready read port.
//  - Sits between per-channel producers and a single shared consumer.
// PARAMETERS
//  NUM_CH    4  number of slots/channels (>=2, need not be a power of 2)
//  DATA_W    8  word width
//  MODE      0  0 = round-robin drain of all slots; 1 = drain only FIXED_CH
//  FIXED_CH  2  slot drained in MODE 1; must be < NUM_CH (elaboration $error otherwise)
//  SEL_W     localparam = $clog2(NUM_CH)
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst_n        in   1       synchronous reset, active-low
//  wr_valid     in   1       write request
//  wr_ch        in   SEL_W   target slot index
//  wr_data      in   DATA_W  write word
//  wr_ready     out  1       write accepted this cycle when wr_valid && wr_ready
//  rd_valid     out  1       output word valid
//  rd_ready     in   1       consumer accepts the output word
//  rd_data      out  DATA_W  output word
//  rd_ch        out  SEL_W   slot the output word came from
//  slot_busy    out  NUM_CH  per-slot occupied flags (registered)
//  rd_par_err   out  1       parity mismatch on the current output word (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rst_n==0 at a posedge clears the following, regardless of state:
//    - slot_busy = 0, rd_valid = 0, rd_data = 0, rd_ch = 0, rd_par_err = 0
//    - FSM = IDLE; round-robin pointer last_ch = NUM_CH-1, so the first scan starts at slot 0
//  - wr_ready (combinational) = (wr_ch < NUM_CH) && (!slot_busy[wr_ch] || slot drained this cycle).
//    - An out-of-range wr_ch is never accepted.
//  - An accepted write sets slot_busy[wr_ch] and stores wr_data at the next edge.
//  - FSM states: IDLE, HOLD.
//    - Eligible slots: MODE 0 = all busy slots; MODE 1 = FIXED_CH only.
//    - Pick rule: first eligible busy slot scanning last_ch+1, last_ch+2, ... modulo NUM_CH.
//    - IDLE: if any eligible slot is busy, on that edge:
//      - load rd_data/rd_ch from the picked slot and clear its busy flag;
//      - set last_ch = picked slot and rd_valid = 1; go to HOLD.
//    - HOLD, rd_ready=0: all outputs stable; no slot is drained.
//    - HOLD, rd_ready=1:
//      - another eligible busy slot exists: load it on the same edge (back-to-back, no bubble) and stay in HOLD;
//      - otherwise: rd_valid = 0, go to IDLE.
//  - Latency: write accepted at edge t -> busy at t -> rd_valid at t+1 (from IDLE). Minimum 1 cycle.
//  - Same-cycle write to a slot being drained: the drain captures the old word; the new word is
//    stored and the slot stays busy.
//  - Slots are never overwritten while busy. Back-pressure is applied per slot only.
//  - MODE 1: slots other than FIXED_CH fill up and then hold wr_ready low for their index indefinitely.
// CONFIGURATION
//  - CHAN_SEL_PARITY_EN defined:
//    - each chan_slot stores the even parity of wr_data alongside the word;
//    - on load, rd_par_err = (^rd_data != stored parity);
//    - chan_slot exposes a force_par_flip test input, used by the bench only.
//  - CHAN_SEL_PARITY_EN undefined: no parity storage; rd_par_err tied to 0.
// STRUCTURE
//  - Package chan_sel_pkg holds:
//    - typedef enum logic [0:0] {IDLE, HOLD} chan_sel_state_e;
//    - localparams MODE_RR = 0 and MODE_FIXED = 1.
//  - Sub-module chan_slot (one per channel, generate loop chan_loop): busy flag, data register and
//    optional parity bit, with set and clear strobes.
//  - Top level: write decode, pick logic, FSM, output register.
// TESTING
//  1. Reset -> all outputs 0.
//     Write ch1=0xA5 -> rd_valid=1 one cycle later with rd_data=0xA5, rd_ch=1, slot_busy=0.
//  2. MODE 0, fill ch0..3 with 0x10..0x13, rd_ready=1 -> outputs in order ch0,1,2,3 back-to-back,
//     then rd_valid=0.
//  3. Hold rd_ready=0 while ch2 is busy; write ch2 again -> wr_ready=0 and rd_data is stable.
//     Then release rd_ready -> drain proceeds.
//  4. MODE 1, FIXED_CH=2, NUM_CH=3: write ch0, ch2 -> only ch2 drained; ch0 stays busy.
//     A write to wr_ch=3 -> wr_ready=0.
//  5. Drop rst_n in HOLD with 3 slots busy -> next cycle rd_valid=0, slot_busy=0.
//     A new write after reset drains starting from slot 0.
//  6. With CHAN_SEL_PARITY_EN, force a parity flip on ch1 -> rd_par_err=1 with rd_ch=1.
//     Without the macro -> rd_par_err stays 0.

Source files
------------

// File: rtl/chan_sel_pkg.sv
// Shared types and mode encodings for the chan_sel_array slice.
package chan_sel_pkg;

  typedef enum logic [0:0] {IDLE, HOLD} chan_sel_state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage

// File: rtl/chan_slot.sv
// Single-word holding slot: busy flag, data register and, with CHAN_SEL_PARITY_EN,
// a stored even-parity bit. A set on the same edge as a clear wins (refill while draining).
module chan_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef CHAN_SEL_PARITY_EN
  input  logic              force_par_flip,
  output logic              par,
`endif
  output logic              busy,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      data <= '0;
    end else if (set) begin
      busy <= 1'b1;
      data <= wr_data;
    end else if (clr) begin
      busy <= 1'b0;
    end
  end

`ifdef CHAN_SEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (set) begin
      par <= (^wr_data) ^ force_par_flip;
    end
  end
`endif

endmodule

// File: rtl/chan_sel_array.sv
// Multi-channel holding array with a round-robin / fixed-channel drain FSM and a
// valid/ready read port. Optional parity storage and checking under CHAN_SEL_PARITY_EN.
module chan_sel_array
  import chan_sel_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 8,
  parameter  int MODE     = 0,
  parameter  int FIXED_CH = 2,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [SEL_W-1:0]  wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [SEL_W-1:0]  rd_ch,
  output logic [NUM_CH-1:0] slot_busy,
`ifdef CHAN_SEL_PARITY_EN
  input  logic [NUM_CH-1:0] force_par_flip,
`endif
  output logic              rd_par_err
);

  localparam logic [NUM_CH-1:0] FIXED_MASK = NUM_CH'(1) << FIXED_CH;

  if (FIXED_CH >= NUM_CH) begin : g_fixed_chk
    $error("chan_sel_array: FIXED_CH (%0d) must be < NUM_CH (%0d)", FIXED_CH, NUM_CH);
  end
  if (NUM_CH < 2) begin : g_num_chk
    $error("chan_sel_array: NUM_CH (%0d) must be >= 2", NUM_CH);
  end

  chan_sel_state_e   state, state_nxt;
  logic [NUM_CH-1:0] slot_set, slot_clr, elig;
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic [SEL_W-1:0]  last_ch, pick, scan_idx;
  logic              any_elig, drain, wr_in_range;

  for (genvar i = 0; i < NUM_CH; i++) begin : chan_loop
    chan_slot #(.DATA_W(DATA_W)) slot_inst (
      .clk            (clk),
      .rst_n          (rst_n),
      .set            (slot_set[i]),
      .clr            (slot_clr[i]),
      .wr_data        (wr_data),
`ifdef CHAN_SEL_PARITY_EN
      .force_par_flip (force_par_flip[i]),
      .par            (),
`endif
      .busy           (slot_busy[i]),
      .data           (slot_data[i])
    );
  end

  // Write side: a slot being drained this cycle can be refilled on the same edge.
  assign wr_in_range = 32'(wr_ch) < NUM_CH;

  always_comb begin
    wr_ready = 1'b0;
    if (wr_in_range) begin
      wr_ready = !slot_busy[wr_ch] || (drain && (pick == wr_ch));
    end
  end

  always_comb begin
    slot_set = '0;
    slot_clr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot_set[i] = wr_valid && wr_ready && (32'(wr_ch) == i);
      slot_clr[i] = drain && (32'(pick) == i);
    end
  end

  always_comb begin
    if (MODE == MODE_FIXED) elig = slot_busy & FIXED_MASK;
    else                    elig = slot_busy;
  end

  // Round-robin pick: first eligible slot after last_ch, wrapping modulo NUM_CH.
  always_comb begin
    pick     = '0;
    any_elig = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      scan_idx = SEL_W'((32'(last_ch) + k) % NUM_CH);
      if (!any_elig && elig[scan_idx]) begin
        any_elig = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = HOLD;
      HOLD:    if (rd_ready && !any_elig) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid = (state == HOLD);
    drain    = any_elig && ((state == IDLE) || rd_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_ch   <= '0;
      last_ch <= SEL_W'(NUM_CH - 1);
    end else if (drain) begin
      rd_data <= slot_data[pick];
      rd_ch   <= pick;
      last_ch <= pick;
    end
  end

`ifdef CHAN_SEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_par_err <= 1'b0;
    end else if (drain) begin
      rd_par_err <= (^slot_data[pick]) != chan_loop_par(pick);
    end
  end

  logic [NUM_CH-1:0] slot_par;
  for (genvar i = 0; i < NUM_CH; i++) begin : par_loop
    assign slot_par[i] = chan_loop[i].slot_inst.par;
  end

  function automatic logic chan_loop_par(input logic [SEL_W-1:0] idx);
    return slot_par[idx];
  endfunction
`else
  assign rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_chan_sel_array.sv
// Directed bench: a round-robin 4-channel instance and a fixed-channel 3-channel instance.
module tb_chan_sel_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready, a_rd_par_err;
  logic [1:0] a_wr_ch, a_rd_ch;
  logic [7:0] a_wr_data, a_rd_data;
  logic [3:0] a_slot_busy;
`ifdef CHAN_SEL_PARITY_EN
  logic [3:0] a_flip;
  logic [2:0] b_flip;
`endif

  logic       b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_rd_par_err;
  logic [1:0] b_wr_ch, b_rd_ch;
  logic [7:0] b_wr_data, b_rd_data;
  logic [2:0] b_slot_busy;

  chan_sel_array #(.NUM_CH(4), .DATA_W(8), .MODE(0), .FIXED_CH(2)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(a_wr_valid), .wr_ch(a_wr_ch), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data), .rd_ch(a_rd_ch),
    .slot_busy(a_slot_busy),
`ifdef CHAN_SEL_PARITY_EN
    .force_par_flip(a_flip),
`endif
    .rd_par_err(a_rd_par_err)
  );

  chan_sel_array #(.NUM_CH(3), .DATA_W(8), .MODE(1), .FIXED_CH(2)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(b_wr_valid), .wr_ch(b_wr_ch), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_ch(b_rd_ch),
    .slot_busy(b_slot_busy),
`ifdef CHAN_SEL_PARITY_EN
    .force_par_flip(b_flip),
`endif
    .rd_par_err(b_rd_par_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [1:0] ch, input logic [7:0] d);
    a_wr_valid = 1'b1;
    a_wr_ch    = ch;
    a_wr_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_wr_valid = 1'b0; a_wr_ch = '0; a_wr_data = '0; a_rd_ready = 1'b0;
    b_wr_valid = 1'b0; b_wr_ch = '0; b_wr_data = '0; b_rd_ready = 1'b0;
`ifdef CHAN_SEL_PARITY_EN
    a_flip = '0;
    b_flip = '0;
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // 1: reset state, single write latency
    chk("rst_rd_valid", 32'(a_rd_valid), 0);
    chk("rst_rd_data",  32'(a_rd_data), 0);
    chk("rst_rd_ch",    32'(a_rd_ch), 0);
    chk("rst_busy",     32'(a_slot_busy), 0);
    chk("rst_par_err",  32'(a_rd_par_err), 0);
    chk("rst_b_busy",   32'(b_slot_busy), 0);
    a_write(2'd1, 8'hA5);
    #1;
    chk("t1_wr_ready", 32'(a_wr_ready), 1);
    tick();
    a_wr_valid = 1'b0;
    chk("t1_busy_set", 32'(a_slot_busy), 32'h2);
    chk("t1_not_valid_yet", 32'(a_rd_valid), 0);
    tick();
    chk("t1_rd_valid", 32'(a_rd_valid), 1);
    chk("t1_rd_data",  32'(a_rd_data), 32'hA5);
    chk("t1_rd_ch",    32'(a_rd_ch), 1);
    chk("t1_busy_clr", 32'(a_slot_busy), 0);
    a_rd_ready = 1'b1;
    tick();
    chk("t1_idle", 32'(a_rd_valid), 0);

    // 2: fill ch0..3 while draining back-to-back
    for (int i = 0; i < 6; i++) begin
      if (i < 4) a_write(2'(i), 8'(8'h10 + i));
      else       a_wr_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 4) begin
        chk("t2_valid", 32'(a_rd_valid), 1);
        chk("t2_ch",    32'(a_rd_ch), 32'(i - 1));
        chk("t2_data",  32'(a_rd_data), 32'(8'h10 + i - 1));
      end
    end
    chk("t2_end_valid", 32'(a_rd_valid), 0);
    chk("t2_end_busy",  32'(a_slot_busy), 0);

    // 3: back-pressure, same-cycle refill, blocked write
    a_rd_ready = 1'b0;
    a_write(2'd2, 8'h22);
    #1;
    chk("t3_wr_ready_free", 32'(a_wr_ready), 1);
    tick();
    a_write(2'd2, 8'h33);
    #1;
    chk("t3_wr_ready_drain", 32'(a_wr_ready), 1);
    tick();
    chk("t3_rd_data_old", 32'(a_rd_data), 32'h22);
    chk("t3_busy_refill", 32'(a_slot_busy), 32'h4);
    a_write(2'd2, 8'h44);
    #1;
    chk("t3_wr_ready_blk", 32'(a_wr_ready), 0);
    tick();
    a_wr_valid = 1'b0;
    tick();
    chk("t3_stable_data", 32'(a_rd_data), 32'h22);
    chk("t3_stable_valid", 32'(a_rd_valid), 1);
    chk("t3_stable_busy", 32'(a_slot_busy), 32'h4);
    a_rd_ready = 1'b1;
    tick();
    chk("t3_next_data", 32'(a_rd_data), 32'h33);
    chk("t3_next_ch",   32'(a_rd_ch), 2);
    tick();
    chk("t3_done_valid", 32'(a_rd_valid), 0);
    chk("t3_done_busy",  32'(a_slot_busy), 0);

    // 4: fixed mode, 3 channels, drain only ch2
    b_wr_valid = 1'b1; b_wr_ch = 2'd0; b_wr_data = 8'h40;
    #1;
    chk("t4_wr0_ready", 32'(b_wr_ready), 1);
    tick();
    b_wr_ch = 2'd2; b_wr_data = 8'h42;
    tick();
    b_wr_valid = 1'b0;
    chk("t4_busy_both", 32'(b_slot_busy), 32'h5);
    chk("t4_no_drain0", 32'(b_rd_valid), 0);
    tick();
    chk("t4_rd_valid", 32'(b_rd_valid), 1);
    chk("t4_rd_ch",    32'(b_rd_ch), 2);
    chk("t4_rd_data",  32'(b_rd_data), 32'h42);
    chk("t4_busy_ch0", 32'(b_slot_busy), 32'h1);
    b_wr_ch = 2'd0;
    #1;
    chk("t4_ready_ch0", 32'(b_wr_ready), 0);
    b_wr_ch = 2'd3;
    #1;
    chk("t4_ready_oor", 32'(b_wr_ready), 0);
    b_wr_ch = 2'd1;
    #1;
    chk("t4_ready_ch1", 32'(b_wr_ready), 1);
    b_rd_ready = 1'b1;
    tick();
    tick();
    chk("t4_end_valid", 32'(b_rd_valid), 0);
    chk("t4_end_busy",  32'(b_slot_busy), 32'h1);

    // 5: reset while holding with three slots busy
    a_rd_ready = 1'b0;
    a_write(2'd0, 8'h50); tick();
    a_write(2'd1, 8'h51); tick();
    a_write(2'd3, 8'h53); tick();
    a_write(2'd2, 8'h52); tick();
    a_wr_valid = 1'b0;
    chk("t5_hold_ch",   32'(a_rd_ch), 0);
    chk("t5_hold_busy", 32'(a_slot_busy), 32'hE);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_valid", 32'(a_rd_valid), 0);
    chk("t5_rst_busy",  32'(a_slot_busy), 0);
    chk("t5_rst_data",  32'(a_rd_data), 0);
    chk("t5_rst_ch",    32'(a_rd_ch), 0);
    a_write(2'd0, 8'h60); tick();
    a_wr_valid = 1'b0;
    tick();
    chk("t5_after_ch",   32'(a_rd_ch), 0);
    chk("t5_after_data", 32'(a_rd_data), 32'h60);
    a_rd_ready = 1'b1;
    tick();
    chk("t5_after_idle", 32'(a_rd_valid), 0);

    // 6: parity error reporting
`ifdef CHAN_SEL_PARITY_EN
    a_flip = 4'b0010;
    a_write(2'd1, 8'h03); tick();
    a_wr_valid = 1'b0;
    a_flip = '0;
    tick();
    chk("t6_flip_ch",  32'(a_rd_ch), 1);
    chk("t6_flip_err", 32'(a_rd_par_err), 1);
    tick();
    a_write(2'd1, 8'h07); tick();
    a_wr_valid = 1'b0;
    tick();
    chk("t6_clean_data", 32'(a_rd_data), 32'h07);
    chk("t6_clean_err",  32'(a_rd_par_err), 0);
`else
    a_write(2'd1, 8'h03); tick();
    a_wr_valid = 1'b0;
    tick();
    chk("t6_nopar_data", 32'(a_rd_data), 32'h03);
    chk("t6_nopar_ch",   32'(a_rd_ch), 1);
    chk("t6_nopar_err",  32'(a_rd_par_err), 0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
